// File: rtl/memory_bus_responder.sv
// memory_bus_responder
//   Answers CPU bus strobes for a 16-bit address space. A small set of
//   addresses is served internally in the same cycle: the interrupt flag
//   register IF (0xFF0F), the interrupt enable register IE (0xFFFF) and the
//   unusable window 0xFEA0-0xFEFF. All other addresses become a request on an
//   external memory port, and the CPU is stalled until that port acknowledges.
//   Each strobe assertion produces exactly one access. A new access can only
//   start once the strobe has been released.
//
// Ports
//   i_Clk, i_Reset              clock, synchronous active-high reset
//   i_Address, i_Address_Out    CPU address bus and its "address valid" strobe
//   i_Bus_In, i_Bus_Out         CPU read / write request (write wins if both)
//   i_Data                      CPU write data
//   o_Data, o_Data_Valid        read data (held) and its one-cycle completion pulse
//   o_Ready                     low while the CPU must stall
//   o_Mem_Req/We/Addr/Wdata     external memory request (held until ack)
//   i_Mem_Rdata, i_Mem_Ack      external memory response
//   i_Irq_Request, i_Irq_Ack    per-bit set / clear of the IF register
//   o_Interrupts                pending and enabled interrupts (IE & IF)
module memory_bus_responder (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [15:0] i_Address,
  input  logic        i_Address_Out,
  input  logic        i_Bus_In,
  input  logic        i_Bus_Out,
  input  logic [7:0]  i_Data,
  output logic [7:0]  o_Data,
  output logic        o_Data_Valid,
  output logic        o_Ready,
  output logic        o_Mem_Req,
  output logic        o_Mem_We,
  output logic [15:0] o_Mem_Addr,
  output logic [7:0]  o_Mem_Wdata,
  input  logic [7:0]  i_Mem_Rdata,
  input  logic        i_Mem_Ack,
  input  logic [4:0]  i_Irq_Request,
  input  logic [4:0]  i_Irq_Ack,
  output logic [4:0]  o_Interrupts
);

  typedef enum logic [1:0] {
    IDLE,    // waiting for a strobe
    ACCESS,  // external request outstanding
    HOLD     // access done, waiting for the strobe to drop
  } state_t;

  localparam logic [15:0] ADDR_IF      = 16'hFF0F;
  localparam logic [15:0] ADDR_IE      = 16'hFFFF;
  localparam logic [15:0] UNUSABLE_LO  = 16'hFEA0;
  localparam logic [15:0] UNUSABLE_HI  = 16'hFEFF;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] addr_q;
  logic [4:0]  if_q;
  logic [4:0]  if_d;
  logic [7:0]  ie_q;

  logic        strobe;
  logic        start;
  logic        is_write;
  logic        hit_if;
  logic        hit_ie;
  logic        hit_unusable;
  logic        is_internal;
  logic [7:0]  int_rdata;

  // Decode is done on the latched address, so the address phase must precede
  // the strobe by at least one edge.
  assign strobe       = i_Bus_In | i_Bus_Out;
  assign start        = (state_q == IDLE) && strobe;
  assign is_write     = i_Bus_Out;
  assign hit_if       = (addr_q == ADDR_IF);
  assign hit_ie       = (addr_q == ADDR_IE);
  assign hit_unusable = (addr_q >= UNUSABLE_LO) && (addr_q <= UNUSABLE_HI);
  assign is_internal  = hit_if | hit_ie | hit_unusable;

  assign o_Interrupts = ie_q[4:0] & if_q;

  // Internal read mux; the unusable window reads as all ones.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int_rdata = 8'hFF;
    if (hit_if)      int_rdata = {3'b111, if_q};
    else if (hit_ie) int_rdata = ie_q;
  end

  // IF update per bit: hardware request beats acknowledge beats CPU write.
  always_comb begin
    if_d = if_q;
    for (int i = 0; i < 5; i++) begin
      if (i_Irq_Request[i])                 if_d[i] = 1'b1;
      else if (i_Irq_Ack[i])                if_d[i] = 1'b0;
      else if (start && is_write && hit_if) if_d[i] = i_Data[i];
    end
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (strobe)    state_d = is_internal ? HOLD : ACCESS;
      ACCESS:  if (i_Mem_Ack) state_d = HOLD;
      HOLD:    if (!strobe)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Stall is combinational so the CPU freezes in the very cycle it strobes
  // an external address.
  always_comb begin
    o_Ready = 1'b1;
    unique case (state_q)
      IDLE:    if (strobe && !is_internal) o_Ready = 1'b0;
      ACCESS:  o_Ready = 1'b0;
      default: o_Ready = 1'b1;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      addr_q       <= 16'h0000;
      if_q         <= 5'b0;
      ie_q         <= 8'h00;
      o_Data       <= 8'h00;
      o_Data_Valid <= 1'b0;
      o_Mem_Req    <= 1'b0;
      o_Mem_We     <= 1'b0;
      o_Mem_Addr   <= 16'h0000;
      o_Mem_Wdata  <= 8'h00;
    end else begin
      o_Data_Valid <= 1'b0;
      if_q         <= if_d;

      // The address is frozen while an external request is outstanding.
      if (i_Address_Out && (state_q != ACCESS)) addr_q <= i_Address;

      if (start && is_write && hit_ie) ie_q <= i_Data;

      if (start && is_internal && !is_write) begin
        o_Data       <= int_rdata;
        o_Data_Valid <= 1'b1;
      end

      if (start && !is_internal) begin
        o_Mem_Req   <= 1'b1;
        o_Mem_Addr  <= addr_q;
        o_Mem_We    <= is_write;
        o_Mem_Wdata <= i_Data;
      end

      if ((state_q == ACCESS) && i_Mem_Ack) begin
        o_Mem_Req <= 1'b0;
        if (!o_Mem_We) begin
          o_Data       <= i_Mem_Rdata;
          o_Data_Valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_bus_responder.sv
// Testbench for memory_bus_responder: a table of bus accesses with expected
// read data, stall length and interrupt outputs, followed by hand-written
// sequences for stalls, held strobes, IF priority and reset during ACCESS.
// Read data is predicted when a read is issued and compared when
// o_Data_Valid pulses.
module tb_memory_bus_responder;

  logic        i_Clk;
  logic        i_Reset;
  logic [15:0] i_Address;
  logic        i_Address_Out;
  logic        i_Bus_In;
  logic        i_Bus_Out;
  logic [7:0]  i_Data;
  logic [7:0]  o_Data;
  logic        o_Data_Valid;
  logic        o_Ready;
  logic        o_Mem_Req;
  logic        o_Mem_We;
  logic [15:0] o_Mem_Addr;
  logic [7:0]  o_Mem_Wdata;
  logic [7:0]  i_Mem_Rdata;
  logic        i_Mem_Ack;
  logic [4:0]  i_Irq_Request;
  logic [4:0]  i_Irq_Ack;
  logic [4:0]  o_Interrupts;

  memory_bus_responder dut (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_Address     (i_Address),
    .i_Address_Out (i_Address_Out),
    .i_Bus_In      (i_Bus_In),
    .i_Bus_Out     (i_Bus_Out),
    .i_Data        (i_Data),
    .o_Data        (o_Data),
    .o_Data_Valid  (o_Data_Valid),
    .o_Ready       (o_Ready),
    .o_Mem_Req     (o_Mem_Req),
    .o_Mem_We      (o_Mem_We),
    .o_Mem_Addr    (o_Mem_Addr),
    .o_Mem_Wdata   (o_Mem_Wdata),
    .i_Mem_Rdata   (i_Mem_Rdata),
    .i_Mem_Ack     (i_Mem_Ack),
    .i_Irq_Request (i_Irq_Request),
    .i_Irq_Ack     (i_Irq_Ack),
    .o_Interrupts  (o_Interrupts)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  int check_count = 0;
  int pass_count  = 0;

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
  endtask

  // -------------------------------------------- external memory model
  logic [7:0]  mem [logic [15:0]];
  int          ack_delay = 2;
  bit          auto_ack  = 1'b1;
  logic [15:0] exp_mem_addr;
  logic        exp_mem_we;
  logic [7:0]  exp_mem_wdata;

  function automatic logic [7:0] mem_read(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8];
  endfunction

  // Acknowledges in the ack_delay-th cycle that o_Mem_Req is seen high.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge i_Clk);
      #1;
      if (!auto_ack) begin
        cnt = 0;
      end else if (i_Mem_Ack) begin
        i_Mem_Ack = 1'b0;
        cnt = 0;
      end else if (o_Mem_Req === 1'b1) begin
        cnt++;
        if (cnt == ack_delay) begin
          check("mem_addr",  o_Mem_Addr,  exp_mem_addr);
          check("mem_we",    o_Mem_We,    exp_mem_we);
          check("mem_wdata", o_Mem_Wdata, exp_mem_wdata);
          if (o_Mem_We === 1'b1) mem[o_Mem_Addr] = o_Mem_Wdata;
          i_Mem_Rdata = mem_read(o_Mem_Addr);
          i_Mem_Ack   = 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------ scoreboard/monitor
  logic [7:0] sb_q [$];
  int         valid_count = 0;
  int         req_rises   = 0;

  initial begin
    logic req_prev = 1'b0;
    forever begin
      @(negedge i_Clk);
      if ((o_Mem_Req === 1'b1) && !req_prev) req_rises++;
      req_prev = (o_Mem_Req === 1'b1);
      if (o_Data_Valid === 1'b1) begin
        valid_count++;
        check("valid_expected", (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) check("rdata", o_Data, sb_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------- drivers
  // Address phase, then one strobe cycle-run until o_Ready, then release.
  task automatic access(input logic wr, input logic rd, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata,
                        output int stall);
    bit done = 1'b0;
    exp_mem_addr  = addr;
    exp_mem_we    = wr;
    exp_mem_wdata = wdata;
    if (rd && !wr) sb_q.push_back(exp_rdata);
    @(posedge i_Clk); #1;
    i_Address     = addr;
    i_Address_Out = 1'b1;
    @(posedge i_Clk); #1;
    i_Address_Out = 1'b0;
    i_Bus_In      = rd;
    i_Bus_Out     = wr;
    i_Data        = wdata;
    stall = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_Clk);
      if (o_Ready === 1'b1) begin
        done = 1'b1;
        break;
      end
      stall++;
    end
    if (!done) check("ready_timeout", 1'b0, 1'b1);
    @(posedge i_Clk); #1;
    i_Bus_In  = 1'b0;
    i_Bus_Out = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge i_Clk); #1;
    i_Reset = 1'b1;
    @(posedge i_Clk); #1;
    i_Reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},   o_Data,       8'h00);
    check({tag, "_valid"},  o_Data_Valid, 1'b0);
    check({tag, "_req"},    o_Mem_Req,    1'b0);
    check({tag, "_we"},     o_Mem_We,     1'b0);
    check({tag, "_addr"},   o_Mem_Addr,   16'h0000);
    check({tag, "_wdata"},  o_Mem_Wdata,  8'h00);
    check({tag, "_ready"},  o_Ready,      1'b1);
    check({tag, "_ints"},   o_Interrupts, 5'b0);
  endtask

  // One CPU write to IF in the same cycle as interrupt set/clear requests.
  task automatic if_write_with_irq(input logic [7:0] wdata, input logic [4:0] req,
                                   input logic [4:0] ack);
    @(posedge i_Clk); #1;
    i_Address     = 16'hFF0F;
    i_Address_Out = 1'b1;
    @(posedge i_Clk); #1;
    i_Address_Out = 1'b0;
    i_Bus_Out     = 1'b1;
    i_Data        = wdata;
    i_Irq_Request = req;
    i_Irq_Ack     = ack;
    @(negedge i_Clk);
    check("if_write_ready", o_Ready, 1'b1);
    @(posedge i_Clk); #1;
    i_Bus_Out     = 1'b0;
    i_Irq_Request = 5'b0;
    i_Irq_Ack     = 5'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic [4:0]  exp_ints;
    int          exp_stall;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int stall;
    int v0;
    int r0;

    vecs[0]  = '{1'b1, 1'b0, 16'hFFFF, 8'h1F, 8'h00, 5'h00, 0};
    vecs[1]  = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h1F, 5'h00, 0};
    vecs[2]  = '{1'b0, 1'b1, 16'hFF0F, 8'h00, 8'hE0, 5'h00, 0};
    vecs[3]  = '{1'b1, 1'b0, 16'hFEA0, 8'hAB, 8'h00, 5'h00, 0};
    vecs[4]  = '{1'b0, 1'b1, 16'hFEA0, 8'h00, 8'hFF, 5'h00, 0};
    vecs[5]  = '{1'b0, 1'b1, 16'hFEFF, 8'h00, 8'hFF, 5'h00, 0};
    vecs[6]  = '{1'b1, 1'b0, 16'h1234, 8'h3C, 8'h00, 5'h00, 3};
    vecs[7]  = '{1'b0, 1'b1, 16'h1234, 8'h00, 8'h3C, 5'h00, 3};
    vecs[8]  = '{1'b0, 1'b1, 16'hFE9F, 8'h00, 8'h61, 5'h00, 3};
    vecs[9]  = '{1'b0, 1'b1, 16'hFF10, 8'h00, 8'hEF, 5'h00, 3};
    vecs[10] = '{1'b1, 1'b0, 16'hFF0F, 8'h0A, 8'h00, 5'h0A, 0};
    vecs[11] = '{1'b0, 1'b1, 16'hFF0F, 8'h00, 8'hEA, 5'h0A, 0};
    vecs[12] = '{1'b1, 1'b0, 16'hFFFF, 8'h03, 8'h00, 5'h02, 0};
    vecs[13] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h03, 5'h02, 0};
    vecs[14] = '{1'b1, 1'b0, 16'hFFFF, 8'hFF, 8'h00, 5'h0A, 0};
    vecs[15] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 8'hFF, 5'h0A, 0};
    vecs[16] = '{1'b0, 1'b1, 16'hFFFE, 8'h00, 8'h01, 5'h0A, 3};

    i_Reset       = 1'b1;
    i_Address     = 16'h0000;
    i_Address_Out = 1'b0;
    i_Bus_In      = 1'b0;
    i_Bus_Out     = 1'b0;
    i_Data        = 8'h00;
    i_Mem_Rdata   = 8'h00;
    i_Mem_Ack     = 1'b0;
    i_Irq_Request = 5'b0;
    i_Irq_Ack     = 5'b0;
    repeat (2) @(posedge i_Clk);
    #1 i_Reset = 1'b0;
    @(negedge i_Clk);
    check_reset_values("reset");

    // Table of single accesses.
    for (int i = 0; i < 17; i++) begin
      access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, stall);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      @(negedge i_Clk);
      check($sformatf("vec%0d_ints", i), o_Interrupts, vecs[i].exp_ints);
    end

    // Read of 0x0150 acknowledged in the third ACCESS cycle.
    ack_delay = 3;
    mem[16'h0150] = 8'hC3;
    v0 = valid_count;
    access(1'b0, 1'b1, 16'h0150, 8'h00, 8'hC3, stall);
    check("ext_read_stall", stall, 4);
    @(negedge i_Clk);
    check("ext_read_data", o_Data, 8'hC3);
    check("ext_read_pulses", valid_count - v0, 1);
    check("ext_read_we", o_Mem_We, 1'b0);
    ack_delay = 2;

    // Strobe held for six cycles must give one request and one pulse.
    v0 = valid_count;
    r0 = req_rises;
    sb_q.push_back(8'hC0);
    exp_mem_addr  = 16'hC000;
    exp_mem_we    = 1'b0;
    exp_mem_wdata = 8'h00;
    @(posedge i_Clk); #1;
    i_Address     = 16'hC000;
    i_Address_Out = 1'b1;
    @(posedge i_Clk); #1;
    i_Address_Out = 1'b0;
    i_Data        = 8'h00;
    i_Bus_In      = 1'b1;
    repeat (5) @(posedge i_Clk);
    @(negedge i_Clk);
    check("held_ready_in_hold", o_Ready, 1'b1);
    @(posedge i_Clk); #1;
    i_Bus_In = 1'b0;
    repeat (3) @(negedge i_Clk);
    check("held_req_count", req_rises - r0, 1);
    check("held_valid_count", valid_count - v0, 1);
    check("held_req_low", o_Mem_Req, 1'b0);

    // Read and write strobes together: write wins.
    v0 = valid_count;
    access(1'b1, 1'b1, 16'h8000, 8'h55, 8'h00, stall);
    check("both_stall", stall, 3);
    @(negedge i_Clk);
    check("both_we", o_Mem_We, 1'b1);
    check("both_wdata", o_Mem_Wdata, 8'h55);
    check("both_no_valid", valid_count - v0, 0);
    access(1'b0, 1'b1, 16'h8000, 8'h00, 8'h55, stall);

    // Enable all, raise bit 2, read IF without a stall.
    apply_reset();
    access(1'b1, 1'b0, 16'hFFFF, 8'h1F, 8'h00, stall);
    @(posedge i_Clk); #1;
    i_Irq_Request = 5'b00100;
    @(posedge i_Clk); #1;
    i_Irq_Request = 5'b0;
    @(negedge i_Clk);
    check("irq_ints", o_Interrupts, 5'b00100);
    access(1'b0, 1'b1, 16'hFF0F, 8'h00, 8'hE4, stall);
    check("irq_read_stall", stall, 0);

    // Request beats acknowledge beats CPU write.
    if_write_with_irq(8'h00, 5'b00001, 5'b00001);
    @(negedge i_Clk);
    check("prio_req_ints", o_Interrupts, 5'b00001);
    access(1'b0, 1'b1, 16'hFF0F, 8'h00, 8'hE1, stall);
    if_write_with_irq(8'h06, 5'b00000, 5'b00010);
    @(negedge i_Clk);
    check("prio_ack_ints", o_Interrupts, 5'b00100);
    access(1'b0, 1'b1, 16'hFF0F, 8'h00, 8'hE4, stall);

    // Reset during ACCESS, then a late acknowledge.
    auto_ack = 1'b0;
    @(posedge i_Clk); #1;
    i_Address     = 16'h2000;
    i_Address_Out = 1'b1;
    @(posedge i_Clk); #1;
    i_Address_Out = 1'b0;
    i_Bus_In      = 1'b1;
    @(posedge i_Clk); #1;
    @(negedge i_Clk);
    check("rst_access_req", o_Mem_Req, 1'b1);
    check("rst_access_ready", o_Ready, 1'b0);
    @(posedge i_Clk); #1;
    i_Reset       = 1'b1;
    i_Irq_Request = 5'b11111;
    @(posedge i_Clk); #1;
    i_Reset       = 1'b0;
    i_Bus_In      = 1'b0;
    i_Irq_Request = 5'b0;
    i_Mem_Rdata   = 8'h99;
    i_Mem_Ack     = 1'b1;
    @(negedge i_Clk);
    check_reset_values("rst_access");
    @(posedge i_Clk); #1;
    i_Mem_Ack = 1'b0;
    @(negedge i_Clk);
    check("late_ack_valid", o_Data_Valid, 1'b0);
    check("late_ack_data", o_Data, 8'h00);
    check("late_ack_req", o_Mem_Req, 1'b0);
    auto_ack = 1'b1;
    access(1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h00, stall);
    access(1'b0, 1'b1, 16'hFF0F, 8'h00, 8'hE0, stall);

    repeat (2) @(negedge i_Clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
